// File: rtl/audio_tone_arbiter.sv
// -----------------------------------------------------------------------------
// audio_tone_arbiter
//
// Shares one square-wave tone generator among NUM_REQ sound requesters.
// A fixed-priority arbiter (index 0 highest) grants one requester, latches its
// half-period and duration, plays the tone for that many cycles and mixes it
// onto the passthrough microphone samples going back to Audio_Controller.
//
// Optional build macro: AUDIO_TONE_PREEMPT_EN
//   When defined, a higher-priority request arriving during PLAY aborts the
//   current tone (no done pulse) and goes straight to LATCH for the new winner.
//
// Ports:
//   CLOCK_50                 system clock
//   resetn                   asynchronous active-low reset
//   req                      level request per requester
//   req_delay                packed half-periods, slice i for requester i
//   req_dur                  packed durations, slice i for requester i
//   grant                    one-hot grant, zero when idle
//   done                     one-cycle completion pulse to the granted requester
//   busy                     high whenever the FSM is not IDLE
//   audio_in_available       Audio_Controller has an input sample
//   left/right_channel_audio_in   microphone samples
//   audio_out_allowed        Audio_Controller can accept an output sample
//   read_audio_in            consume the input sample
//   write_audio_out          push the output sample
//   left/right_channel_audio_out  microphone samples plus tone (modulo 2^32)
// -----------------------------------------------------------------------------
module audio_tone_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter int          DELAY_W   = 19,
    parameter int          DUR_W     = 23,
    parameter logic [31:0] AMPLITUDE = 32'd10000000
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DELAY_W-1:0] req_delay,
    input  logic [NUM_REQ*DUR_W-1:0]   req_dur,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    input  logic                       audio_in_available,
    input  logic [31:0]                left_channel_audio_in,
    input  logic [31:0]                right_channel_audio_in,
    input  logic                       audio_out_allowed,
    output logic                       read_audio_in,
    output logic                       write_audio_out,
    output logic [31:0]                left_channel_audio_out,
    output logic [31:0]                right_channel_audio_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_PLAY, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]    r_done, w_done_nxt;
    logic [DELAY_W-1:0]    r_dcnt, w_dcnt_nxt;
    logic [DUR_W-1:0]      r_tcnt, w_tcnt_nxt;
    logic                  r_snd, w_snd_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [DELAY_W-1:0]    r_delay;
    logic [DUR_W-1:0]      r_dur;

    logic                  w_win_vld;
    logic [IDX_W-1:0]      w_win_idx;
    logic [NUM_REQ-1:0]    w_win_oh;
    logic                  w_load;
    logic                  w_preempt;
    logic signed [31:0]    w_tone;

    // Square-wave value; silent outside PLAY or when the half-period is zero.
    function automatic logic signed [31:0] tone_f(input logic play,
                                                  input logic [DELAY_W-1:0] delay,
                                                  input logic snd);
        logic signed [31:0] t;
        t = '0;
        if (play && (delay != '0))
            t = snd ? $signed(AMPLITUDE) : -$signed(AMPLITUDE);
        return t;
    endfunction

    // Plain wrap-around mix, no saturation.
    function automatic logic [31:0] mix_f(input logic [31:0] s,
                                          input logic signed [31:0] t);
        return s + $unsigned(t);
    endfunction

    // Lowest set index wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win_vld = 1'b1;
                w_win_idx = IDX_W'(i);
            end
        end
    end

    assign w_win_oh = NUM_REQ'(1) << w_win_idx;

`ifdef AUDIO_TONE_PREEMPT_EN
    assign w_preempt = w_win_vld && (w_win_idx < r_idx);
`else
    assign w_preempt = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_dcnt_nxt  = r_dcnt;
        w_tcnt_nxt  = r_tcnt;
        w_snd_nxt   = r_snd;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                if (w_win_vld) begin
                    w_state_nxt = S_LATCH;
                    w_grant_nxt = w_win_oh;
                    w_load      = 1'b1;
                end
            end
            S_LATCH: begin
                w_dcnt_nxt = '0;
                w_tcnt_nxt = '0;
                w_snd_nxt  = 1'b1;
                if (r_dur == '0) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = r_grant;
                end else begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_preempt) begin
                    w_state_nxt = S_LATCH;
                    w_grant_nxt = w_win_oh;
                    w_load      = 1'b1;
                end else if (!req[r_idx]) begin
                    // Requester withdrew: abort silently.
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                end else begin
                    w_tcnt_nxt = r_tcnt + DUR_W'(1);
                    if (r_dcnt == r_delay) begin
                        w_dcnt_nxt = '0;
                        // A zero half-period is silence, so snd is held.
                        if (r_delay != '0)
                            w_snd_nxt = ~r_snd;
                    end else begin
                        w_dcnt_nxt = r_dcnt + DELAY_W'(1);
                    end
                    if (r_tcnt + DUR_W'(1) == r_dur) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = r_grant;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_dcnt  <= '0;
            r_tcnt  <= '0;
            r_snd   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_snd   <= w_snd_nxt;
        end
    end

    // Request parameters are captured once at grant time; they are only
    // consumed while the FSM is out of IDLE, so they carry no reset.
    always_ff @(posedge CLOCK_50) begin
        if (w_load) begin
            r_idx   <= w_win_idx;
            r_delay <= req_delay[int'(w_win_idx)*DELAY_W +: DELAY_W];
            r_dur   <= req_dur[int'(w_win_idx)*DUR_W +: DUR_W];
        end
    end

    assign w_tone = tone_f(r_state == S_PLAY, r_delay, r_snd);

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = (r_state != S_IDLE);

    assign read_audio_in           = audio_in_available & audio_out_allowed;
    assign write_audio_out         = audio_in_available & audio_out_allowed;
    assign left_channel_audio_out  = mix_f(left_channel_audio_in, w_tone);
    assign right_channel_audio_out = mix_f(right_channel_audio_in, w_tone);

endmodule

// File: tb/tb_audio_tone_arbiter.sv
// -----------------------------------------------------------------------------
// tb_audio_tone_arbiter
//
// Scoreboard bench for audio_tone_arbiter. Stimulus tasks push the expected
// per-cycle {grant, done, left_out, right_out} for every busy cycle; a monitor
// on the falling edge pops one entry per busy cycle and checks passthrough on
// idle cycles. Define AUDIO_TONE_PREEMPT_EN to include the preemption case.
// -----------------------------------------------------------------------------
module tb_audio_tone_arbiter;

    localparam int          NUM_REQ = 4;
    localparam int          DELAY_W = 19;
    localparam int          DUR_W   = 23;
    localparam logic [31:0] AMP     = 32'd10000000;

    typedef struct packed {
        logic [3:0]  g;
        logic [3:0]  dn;
        logic [31:0] l;
        logic [31:0] r;
    } exp_t;

    logic                       clk;
    logic                       resetn;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DELAY_W-1:0] req_delay;
    logic [NUM_REQ*DUR_W-1:0]   req_dur;
    logic [NUM_REQ-1:0]         grant;
    logic [NUM_REQ-1:0]         done;
    logic                       busy;
    logic                       avail;
    logic                       allowed;
    logic [31:0]                left_in;
    logic [31:0]                right_in;
    logic                       rd;
    logic                       wr;
    logic [31:0]                left_out;
    logic [31:0]                right_out;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    audio_tone_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DELAY_W  (DELAY_W),
        .DUR_W    (DUR_W),
        .AMPLITUDE(AMP)
    ) dut (
        .CLOCK_50               (clk),
        .resetn                 (resetn),
        .req                    (req),
        .req_delay              (req_delay),
        .req_dur                (req_dur),
        .grant                  (grant),
        .done                   (done),
        .busy                   (busy),
        .audio_in_available     (avail),
        .left_channel_audio_in  (left_in),
        .right_channel_audio_in (right_in),
        .audio_out_allowed      (allowed),
        .read_audio_in          (rd),
        .write_audio_out        (wr),
        .left_channel_audio_out (left_out),
        .right_channel_audio_out(right_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Square wave: first delay+1 PLAY cycles at +AMP, next delay+1 at -AMP, ...
    function automatic logic [31:0] exp_tone(input int d, input int k);
        logic [31:0] t;
        if (d == 0)
            t = 32'd0;
        else if (((k / (d + 1)) % 2) == 0)
            t = AMP;
        else
            t = 32'd0 - AMP;
        return t;
    endfunction

    task automatic push_txn(input int idx, input int d, input int n_play, input bit with_done);
        exp_t        e;
        logic [3:0]  oh;
        logic [31:0] t;
        oh   = 4'd1 << idx;
        e.g  = oh;
        e.dn = 4'd0;
        e.l  = left_in;
        e.r  = right_in;
        q.push_back(e);
        for (int k = 0; k < n_play; k++) begin
            t   = exp_tone(d, k);
            e.l = left_in + t;
            e.r = right_in + t;
            q.push_back(e);
        end
        if (with_done) begin
            e.dn = oh;
            e.l  = left_in;
            e.r  = right_in;
            q.push_back(e);
        end
    endtask

    task automatic set_slot(input int idx, input int d, input int dur);
        req_delay[idx*DELAY_W +: DELAY_W] = DELAY_W'(d);
        req_dur[idx*DUR_W +: DUR_W]       = DUR_W'(dur);
    endtask

    // Full tone for one requester; called one step after a rising edge, idle.
    task automatic run_tone(input int idx, input int d, input int dur);
        set_slot(idx, d, dur);
        push_txn(idx, d, dur, 1'b1);
        req[idx] = 1'b1;
        @(posedge clk); #1;
        set_slot(idx, 7, 3);        // must be ignored once latched
        repeat (1 + dur) @(posedge clk);
        #1;
        req[idx] = 1'b0;            // now in DONE
        @(posedge clk); #1;
    endtask

    // Monitor: one scoreboard entry per busy cycle, passthrough when idle.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: busy with grant %b done %b, expected no activity", grant, done);
            end else begin
                mon_e = q.pop_front();
                check("sb_cycle", {grant, done, left_out, right_out},
                      {mon_e.g, mon_e.dn, mon_e.l, mon_e.r});
            end
        end else begin
            check("idle_pass", {grant, done, left_out, right_out},
                  {4'd0, 4'd0, left_in, right_in});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        resetn    = 1'b0;
        req       = '0;
        req_delay = '0;
        req_dur   = '0;
        avail     = 1'b1;
        allowed   = 1'b1;
        left_in   = 32'd5;
        right_in  = 32'hFFFF_FFF0;

        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("pass_left", left_out, 32'd5);
        check("pass_rd_wr", {rd, wr}, 2'b11);
        check("post_rst_grant_busy", {grant, busy}, 5'd0);

        for (int i = 0; i < 4; i++) begin
            avail   = i[0];
            allowed = i[1];
            #1;
            check("handshake", {rd, wr}, (i == 3) ? 2'b11 : 2'b00);
        end
        avail   = 1'b1;
        allowed = 1'b1;
        @(posedge clk); #1;

        // Basic tone
        run_tone(2, 3, 16);
        // Edge values
        run_tone(1, 5, 0);
        run_tone(0, 0, 8);

        // Priority: requester 1 beats 3, then 3 after 1 withdraws in DONE
        set_slot(1, 1, 6);
        set_slot(3, 2, 5);
        push_txn(1, 1, 6, 1'b1);
        push_txn(3, 2, 5, 1'b1);
        req = 4'b1010;
        repeat (8) @(posedge clk);
        #1;
        req[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        req[3] = 1'b0;
        @(posedge clk); #1;

        // Abort by withdrawing req[0] in the 5th PLAY cycle
        set_slot(0, 1, 20);
        push_txn(0, 1, 5, 1'b0);
        req[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", {grant, done, busy}, 9'd0);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset in the 5th PLAY cycle
        set_slot(2, 2, 30);
        push_txn(2, 2, 4, 1'b0);
        req[2] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("async_rst_grant_busy", {grant, busy}, 5'd0);
        check("async_rst_tone", {left_out, right_out}, {left_in, right_in});
        req[2] = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

`ifdef AUDIO_TONE_PREEMPT_EN
        // Preemption: req[0] arrives in the 4th PLAY cycle of requester 2
        set_slot(2, 2, 20);
        set_slot(0, 1, 4);
        push_txn(2, 2, 4, 1'b0);
        push_txn(0, 1, 4, 1'b1);
        req[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        req[0] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        req[0] = 1'b0;
        @(posedge clk); #1;
`endif

        begin : drain
            int cyc;
            cyc = 0;
            while (busy === 1'b1 && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("drain_idle", busy, 1'b0);
        end
        @(negedge clk); #1;
        check("sb_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
